// File: rtl/brick_mover.sv
// brick_mover: active-brick controller proposing moves to an external checker.
// Optional lock delay on resting bricks: define BRICK_MOVER_LOCK_DELAY_EN.
module brick_mover #(
  parameter int XW         = 4,
  parameter int YW         = 5,
  parameter int NUM_TYPES  = 7,
  parameter int SPAWN_X    = 6,
  parameter int SPAWN_Y    = 18,
  parameter int DROP_TICKS = 8,
  parameter int LOCK_TICKS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  output logic          cmd_ready,
  input  logic          tick,
  output logic [XW-1:0] try_x,
  output logic [YW-1:0] try_y,
  output logic [1:0]    try_dir,
  output logic [2:0]    try_type,
  input  logic          collided,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic [1:0]    cur_dir,
  output logic [2:0]    cur_type,
  output logic          done,
  output logic          done_ok,
  output logic          place_valid,
  output logic          game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLACE,
    S_SPAWN,
    S_OVER
  } state_e;

  localparam logic [2:0] C_LEFT  = 3'd0;
  localparam logic [2:0] C_RIGHT = 3'd1;
  localparam logic [2:0] C_DOWN  = 3'd2;
  localparam logic [2:0] C_CW    = 3'd3;
  localparam logic [2:0] C_CCW   = 3'd4;
  localparam logic [2:0] C_CYC   = 3'd5;
  localparam logic [2:0] C_HARD  = 3'd6;
  localparam logic [2:0] C_PLACE = 3'd7;

  localparam logic [2:0] NT = 3'(NUM_TYPES);

  // One counter width serves both the gravity and the lock counters.
  localparam int TMAX =
    (DROP_TICKS > LOCK_TICKS) ? DROP_TICKS : LOCK_TICKS;
  localparam int CW = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] G_LAST = CW'(DROP_TICKS - 1);
  localparam logic [XW-1:0] SX     = XW'(SPAWN_X);
  localparam logic [YW-1:0] SY     = YW'(SPAWN_Y);

  state_e        state_q;
  logic [2:0]    op_q;
  logic          grav_op_q;
  logic          hold_done_q;
  logic [XW-1:0] cur_x_q;
  logic [YW-1:0] cur_y_q;
  logic [1:0]    cur_dir_q;
  logic [2:0]    cur_type_q;
  logic [XW-1:0] try_x_q;
  logic [YW-1:0] try_y_q;
  logic [1:0]    try_dir_q;
  logic [2:0]    try_type_q;
  logic          done_q;
  logic          done_ok_q;
  logic          place_q;
  logic          over_q;
  logic [CW-1:0] gcnt_q;
  logic          grav_pend_q;

`ifdef BRICK_MOVER_LOCK_DELAY_EN
  localparam logic [CW-1:0] L_LAST = CW'(LOCK_TICKS - 1);
  logic          lock_act_q;
  logic          lock_fire_q;
  logic [CW-1:0] lcnt_q;
`endif

  logic          grav_fire;
  logic          grav_req;
  logic [2:0]    nxt_type;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic [1:0]    cand_dir;
  logic [2:0]    cand_type;
  logic          guard;

  // A tick completing the count this cycle already blocks commands.
  assign grav_fire = tick && !grav_pend_q &&
                     (state_q != S_OVER) && (gcnt_q == G_LAST);
  assign grav_req  = grav_pend_q || grav_fire;

`ifdef BRICK_MOVER_LOCK_DELAY_EN
  assign cmd_ready = (state_q == S_IDLE) && !grav_req &&
                     !lock_fire_q;
`else
  assign cmd_ready = (state_q == S_IDLE) && !grav_req;
`endif

  assign try_x       = try_x_q;
  assign try_y       = try_y_q;
  assign try_dir     = try_dir_q;
  assign try_type    = try_type_q;
  assign cur_x       = cur_x_q;
  assign cur_y       = cur_y_q;
  assign cur_dir     = cur_dir_q;
  assign cur_type    = cur_type_q;
  assign done        = done_q;
  assign done_ok     = done_ok_q;
  assign place_valid = place_q;
  assign game_over   = over_q;

  // Candidate brick for the incoming command plus the lower-bound guard.
  always_comb begin
    nxt_type  = (cur_type_q == NT) ? 3'd1 : cur_type_q + 3'd1;
    cand_x    = cur_x_q;
    cand_y    = cur_y_q;
    cand_dir  = cur_dir_q;
    cand_type = cur_type_q;
    guard     = 1'b0;
    unique case (cmd)
      C_LEFT: begin
        cand_x = cur_x_q - XW'(1);
        guard  = (cur_x_q == '0);
      end
      C_RIGHT: cand_x = cur_x_q + XW'(1);
      C_DOWN: begin
        cand_y = cur_y_q - YW'(1);
        guard  = (cur_y_q == '0);
      end
      C_HARD:  cand_y    = cur_y_q - YW'(1);
      C_CW:    cand_dir  = cur_dir_q + 2'd1;
      C_CCW:   cand_dir  = cur_dir_q - 2'd1;
      C_CYC:   cand_type = nxt_type;
      C_PLACE: cand_type = cur_type_q;
      default: cand_type = cur_type_q;
    endcase
  end

  // Tick counters and the brick FSM; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= C_LEFT;
      grav_op_q   <= 1'b0;
      hold_done_q <= 1'b0;
      cur_x_q     <= SX;
      cur_y_q     <= SY;
      cur_dir_q   <= 2'd0;
      cur_type_q  <= 3'd1;
      try_x_q     <= SX;
      try_y_q     <= SY;
      try_dir_q   <= 2'd0;
      try_type_q  <= 3'd1;
      done_q      <= 1'b0;
      done_ok_q   <= 1'b0;
      place_q     <= 1'b0;
      over_q      <= 1'b0;
      gcnt_q      <= '0;
      grav_pend_q <= 1'b0;
`ifdef BRICK_MOVER_LOCK_DELAY_EN
      lock_act_q  <= 1'b0;
      lock_fire_q <= 1'b0;
      lcnt_q      <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      done_ok_q <= 1'b0;
      place_q   <= 1'b0;

      if (tick && (state_q != S_OVER) && !grav_pend_q) begin
        if (grav_fire) begin
          gcnt_q      <= '0;
          grav_pend_q <= 1'b1;
        end else begin
          gcnt_q <= gcnt_q + CW'(1);
        end
      end

`ifdef BRICK_MOVER_LOCK_DELAY_EN
      if (tick && (state_q != S_OVER) && lock_act_q) begin
        if (lcnt_q == L_LAST) begin
          lcnt_q      <= '0;
          lock_act_q  <= 1'b0;
          lock_fire_q <= 1'b1;
        end else begin
          lcnt_q <= lcnt_q + CW'(1);
        end
      end
`endif

      unique case (state_q)
        S_IDLE: begin
`ifdef BRICK_MOVER_LOCK_DELAY_EN
          if (lock_fire_q) begin
            lock_fire_q <= 1'b0;
            grav_op_q   <= 1'b1;
            hold_done_q <= 1'b0;
            place_q     <= 1'b1;
            state_q     <= S_PLACE;
          end else
`endif
          if (grav_req) begin
            grav_pend_q <= 1'b0;
            grav_op_q   <= 1'b1;
            op_q        <= C_DOWN;
            if (cur_y_q == '0) begin
              hold_done_q <= 1'b0;
              place_q     <= 1'b1;
              state_q     <= S_PLACE;
            end else begin
              try_x_q    <= cur_x_q;
              try_y_q    <= cur_y_q - YW'(1);
              try_dir_q  <= cur_dir_q;
              try_type_q <= cur_type_q;
              state_q    <= S_CHECK;
            end
          end else if (cmd_valid) begin
            grav_op_q <= 1'b0;
            op_q      <= cmd;
            if ((cmd == C_PLACE) ||
                ((cmd == C_HARD) && (cur_y_q == '0))) begin
              hold_done_q <= 1'b1;
              place_q     <= 1'b1;
              state_q     <= S_PLACE;
            end else if (guard) begin
              done_q <= 1'b1;
            end else begin
              try_x_q    <= cand_x;
              try_y_q    <= cand_y;
              try_dir_q  <= cand_dir;
              try_type_q <= cand_type;
              state_q    <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (!collided) begin
            cur_x_q    <= try_x_q;
            cur_y_q    <= try_y_q;
            cur_dir_q  <= try_dir_q;
            cur_type_q <= try_type_q;
            if (!grav_op_q && (op_q == C_HARD)) begin
              if (try_y_q == '0) begin
                hold_done_q <= 1'b1;
                place_q     <= 1'b1;
                state_q     <= S_PLACE;
              end else begin
                try_y_q <= try_y_q - YW'(1);
              end
            end else begin
              done_q    <= !grav_op_q;
              done_ok_q <= !grav_op_q;
              state_q   <= S_IDLE;
`ifdef BRICK_MOVER_LOCK_DELAY_EN
              if (op_q != C_CYC) begin
                lock_act_q  <= 1'b0;
                lock_fire_q <= 1'b0;
                lcnt_q      <= '0;
              end
`endif
            end
          end else if (!grav_op_q && (op_q == C_HARD)) begin
            hold_done_q <= 1'b1;
            place_q     <= 1'b1;
            state_q     <= S_PLACE;
          end else if (grav_op_q) begin
`ifdef BRICK_MOVER_LOCK_DELAY_EN
            if (!lock_act_q && !lock_fire_q) begin
              lock_act_q <= 1'b1;
              lcnt_q     <= '0;
            end
            state_q <= S_IDLE;
`else
            hold_done_q <= 1'b0;
            place_q     <= 1'b1;
            state_q     <= S_PLACE;
`endif
          end else begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_PLACE: begin
          try_x_q     <= SX;
          try_y_q     <= SY;
          try_dir_q   <= 2'd0;
          try_type_q  <= nxt_type;
          done_q      <= hold_done_q;
          done_ok_q   <= hold_done_q;
          hold_done_q <= 1'b0;
          state_q     <= S_SPAWN;
`ifdef BRICK_MOVER_LOCK_DELAY_EN
          lock_act_q  <= 1'b0;
          lock_fire_q <= 1'b0;
          lcnt_q      <= '0;
`endif
        end

        S_SPAWN: begin
          if (!collided) begin
            cur_x_q    <= try_x_q;
            cur_y_q    <= try_y_q;
            cur_dir_q  <= try_dir_q;
            cur_type_q <= try_type_q;
            state_q    <= S_IDLE;
          end else begin
            over_q  <= 1'b1;
            state_q <= S_OVER;
          end
        end

        S_OVER: begin
          state_q <= S_OVER;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/brick_mover.md
# brick_mover

Parametrised active-brick controller for the Tetris core. It accepts move, rotate, cycle, drop and place commands plus gravity ticks, and proposes each candidate position to an external combinational `collision_check`. It commits the candidate only when the check passes, and emits a one-cycle place strobe so the board owner can write the brick into the placed board. It sits between `keyboard` key pulses and the board/`display` path, and replaces per-test hand-written move FSMs.

## Interface
- `XW`, 4: x coordinate width.
- `YW`, 5: y coordinate width.
- `NUM_TYPES`, 7: brick types are 1..NUM_TYPES; 0 means empty.
- `SPAWN_X`, 6: spawn column.
- `SPAWN_Y`, 18: spawn row.
- `DROP_TICKS`, 8: gravity ticks per automatic down step, ≥1.
- `LOCK_TICKS`, 2: gravity ticks of lock delay; used only with the macro.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd` in 3: 0 LEFT, 1 RIGHT, 2 DOWN, 3 ROT_CW, 4 ROT_CCW, 5 CYCLE_TYPE, 6 HARD_DROP, 7 PLACE.
- `cmd_ready` out 1: high only in IDLE with no gravity step pending.
- `tick` in 1: one-cycle gravity tick pulse.
- `try_x` out XW, `try_y` out YW, `try_dir` out 2, `try_type` out 3: registered candidate, fed to the checker.
- `collided` in 1: combinational checker result for the `try_*` outputs.
- `cur_x` out XW, `cur_y` out YW, `cur_dir` out 2, `cur_type` out 3: committed brick.
- `done` out 1, `done_ok` out 1: one-cycle command completion; `done_ok` is 1 if the command was committed.
- `place_valid` out 1: one-cycle strobe; `cur_*` holds the brick being placed.
- `game_over` out 1: sticky until reset.

## Operation
- States: IDLE, CHECK, PLACE, SPAWN, OVER.
- IDLE, command accepted (`cmd_valid && cmd_ready`):
  - Load `try_*` as `cur_*` with one field changed:
    - LEFT/RIGHT: x∓1.
    - DOWN/HARD_DROP: y−1.
    - ROT_CW/ROT_CCW: dir±1 mod 4.
    - CYCLE_TYPE: type+1, wrapping NUM_TYPES→1.
  - Go to CHECK.
  - PLACE goes directly to PLACE.
- Lower-bound guard: LEFT at x=0 or DOWN at y=0 is rejected without a check. `done=1`, `done_ok=0`, state stays IDLE.
- HARD_DROP at y=0 goes to PLACE.
- CHECK, `collided=0`: commit `try_*` into `cur_*`.
  - HARD_DROP: reload `try_y=cur_y−1` and stay in CHECK, or go to PLACE when the new y is 0.
  - Otherwise: `done=1`, `done_ok=1`, go to IDLE.
- CHECK, `collided=1`: `cur_*` is unchanged.
  - HARD_DROP or gravity down: go to PLACE.
  - Otherwise: `done=1`, `done_ok=0`, go to IDLE.
- PLACE: `place_valid=1` for one cycle, then go to SPAWN.
  - `try_*` is loaded with (SPAWN_X, SPAWN_Y, 0, next type).
  - Next type is `cur_type+1`, wrapping NUM_TYPES→1.
  - `done` for a PLACE or HARD_DROP command asserts with `done_ok=1` at the SPAWN cycle.
- SPAWN, `collided=0`: commit, go to IDLE.
- SPAWN, `collided=1`: go to OVER and set `game_over=1`. `cur_*` keeps the placed brick.
- OVER: ignore all commands and ticks, `cmd_ready=0`. Only reset leaves OVER.
- Gravity counter:
  - Counts ticks in every state except OVER.
  - At the DROP_TICKS-th tick it sets `grav_pend` and clears to 0.
  - In IDLE, `grav_pend` wins over `cmd_valid` in the same cycle: it issues an internal DOWN with no `done`, and clears `grav_pend`.
  - A pending step is held, not lost, while busy; extra ticks while pending are dropped.
- Gravity DOWN at y=0 goes to PLACE.

## Timing
- Reset values:
  - `cur_*` = (SPAWN_X, SPAWN_Y, 0, 1); `try_*` equal the same.
  - All strobes = 0, `game_over` = 0, state IDLE, counters 0.
  - `cmd_ready` = 1.
- Single move: accepted at edge N, `try_*` valid during cycle N+1, `cur_*` updated and `done` high in cycle N+2.
- Guard reject: `done` in cycle N+1.
- Hard drop of k free rows: 1+k CHECK cycles, then PLACE, then SPAWN.
- `collided` is sampled only in CHECK and SPAWN; it is ignored elsewhere.
- Reset mid-operation aborts everything with no `place_valid` or `done`.

## Configuration
- `BRICK_MOVER_LOCK_DELAY_EN` defined:
  - A colliding gravity DOWN starts a lock counter instead of going to PLACE.
  - PLACE happens after LOCK_TICKS further ticks.
  - Any committed LEFT, RIGHT or rotate re-arms the lock, i.e. the next gravity step rechecks.
  - HARD_DROP and PLACE bypass the lock.
- Undefined: a colliding gravity DOWN places immediately; no lock counter is synthesised.

## Test plan
- Reset, LEFT at x=6 with collided=0 → cur_x=5 in cycle N+2, `done_ok=1`.
- RIGHT with collided=1 → cur_x unchanged, `done=1`, `done_ok=0`.
- LEFT at x=0 → `done_ok=0` in cycle N+1, no CHECK state entered.
- HARD_DROP from y=18 with checker colliding at y=14 → cur_y=15, one `place_valid`, spawn at (6,18).
- DROP_TICKS=2, 4 ticks, collided=0 → cur_y 18→16.
  - Tick coinciding with a `cmd_valid` → gravity runs first, and the command is accepted afterwards.
- Spawn with collided=1 → `game_over=1` sticky, `cmd_ready=0`.
  - Assert `rst_n`=0 mid-CHECK → all outputs return to reset values asynchronously.
